div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 divControl  input  1  start request from the control unit, sampled on a rising edge while idle.
REQ-005 a  input  WIDTH  dividend (A register), two's complement, captured at start.
REQ-006 b  input  WIDTH  divisor (B register), two's complement, captured at start.
REQ-007 hi  output  WIDTH  remainder register, feeds HI via hidivControl.
REQ-008 lo  output  WIDTH  quotient register, feeds LO via lodivControl.
REQ-009 div0  output  1  divide-by-zero exception flag to the control unit.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 done  output  1  one-cycle pulse when hi/lo hold a new valid result.

Function
REQ-012 The block SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-013 IDLE: divControl=1 and b!=0 -> capture |a|, |b|, sign(a), sign(a)^sign(b), clear partial remainder, load counter=WIDTH, go CALC.
REQ-014 IDLE: divControl=1 and b==0 -> div0=1 for exactly the next cycle, hi/lo unchanged, done stays 0, remain IDLE.
REQ-015 CALC: one restoring shift-subtract step per cycle, quotient bit MSB first; counter decrements; counter reaching 0 -> FIX.
REQ-016 Partial remainder SHALL be WIDTH+1 bits so the trial subtraction never loses the borrow.
REQ-017 FIX: quotient negated if sign(a)^sign(b)=1; remainder negated if sign(a)=1; results written to lo/hi; go DONE.
REQ-018 DONE: done=1 for one cycle, go IDLE; hi/lo hold until the next completed division or reset.
REQ-019 Latency: with start sampled at edge T, done SHALL be high in the cycle after edge T+WIDTH+2 (34 cycles after start for WIDTH=32).
REQ-020 busy SHALL be 1 in CALC, FIX and DONE, 0 in IDLE.
REQ-021 divControl while busy=1 SHALL be ignored; no queuing.
REQ-022 Semantics SHALL match MIPS DIV: quotient truncates toward zero, remainder takes dividend sign, a = lo*b + hi.
REQ-023 Boundary: a=-2^(WIDTH-1), b=-1 SHALL yield lo=-2^(WIDTH-1) (0x80000000), hi=0, no flag raised.
REQ-024 Boundary: a=0 with any nonzero b SHALL yield lo=0, hi=0 after full latency.
REQ-025 Operand magnitudes SHALL be computed as unsigned WIDTH-bit values so |-2^(WIDTH-1)| = 2^(WIDTH-1) without overflow.
REQ-026 a and b changes after the start edge SHALL NOT affect the result in progress.

Reset
REQ-027 reset low SHALL force state=IDLE, counter=0, hi=0, lo=0, div0=0, busy=0, done=0, and clear all internal operand/sign registers.
REQ-028 reset low mid-CALC or mid-FIX SHALL abort the division; no done pulse and no hi/lo update follows release.
REQ-029 After reset release, a divControl on the first rising edge SHALL be accepted normally.

Verification
REQ-030 a=100, b=7, start at edge T -> done high 34 cycles later, lo=14, hi=2, busy high throughout.
REQ-031 a=-100 (0xFFFFFF9C), b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); a=100, b=-7 -> lo=-14, hi=2.
REQ-032 After a prior result lo=14/hi=2, a=5, b=0 -> div0=1 for one cycle only, done=0, busy=0, lo=14, hi=2 unchanged.
REQ-033 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
REQ-034 Start 100/7, assert reset low at cycle 10 of CALC -> all outputs 0 immediately; release, start 9/3 -> lo=3, hi=0 at normal latency.
REQ-035 Start 100/7, pulse divControl with a=1, b=1 at cycle 5 -> ignored; result lo=14, hi=2 with single done pulse.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - signed restoring divider, MIPS DIV semantics, one quotient bit per cycle
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div0_q, div0_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] trial;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1) exactly.
    assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign trial = {rem_q, quot_q[WIDTH-1]} - {2'b00, dvsr_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (divControl) begin
                    if (b == '0) begin
                        div0_d = 1'b1;
                    end else begin
                        dvsr_d  = b_mag;
                        quot_d  = a_mag;
                        rem_d   = '0;
                        rneg_d  = a[WIDTH-1];
                        qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        count_d = CW'(WIDTH);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (count_q != '0) begin
                    // Dividend bits shift out of quot_q while quotient bits shift in.
                    if (!trial[WIDTH+1]) begin
                        rem_d  = trial[WIDTH:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
                        quot_d = {quot_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q - CW'(1);
                end else begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = qneg_q ? (~quot_q + WIDTH'(1)) : quot_q;
                hi_d    = rneg_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule
